// File: rtl/dcache_wbuf_if.sv
// Signal bundle for the D-cache write-back buffer: eviction input, refill probe, status, AXI aw/w/b.
// The master view is the buffer itself (it is the AXI write master); slave is the cache/bridge side.
interface dcache_wbuf_if #(
    parameter int LINE_WORDS = 8
);
    logic                     wb_valid;
    logic                     wb_ready;
    logic [31:0]              wb_addr;
    logic [LINE_WORDS*32-1:0] wb_data;

    logic [31:0] q_addr;
    logic        q_hit;
    logic [31:0] q_data;
    logic        empty;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        input  wb_valid, wb_addr, wb_data, q_addr, awready, wready, bid, bresp, bvalid,
        output wb_ready, q_hit, q_data, empty,
               awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
               wid, wdata, wstrb, wlast, wvalid, bready
    );

    modport slave (
        output wb_valid, wb_addr, wb_data, q_addr, awready, wready, bid, bresp, bvalid,
        input  wb_ready, q_hit, q_data, empty,
               awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
               wid, wdata, wstrb, wlast, wvalid, bready
    );
endinterface

// File: rtl/dcache_wbuf.sv
// D-cache write-back buffer: FIFO of dirty lines, each drained as one AXI INCR burst, with address probe.
// Optional DCACHE_WBUF_FWD_EN: forward the probed word from the youngest matching entry on q_data.
module dcache_wbuf #(
    parameter int         LINE_WORDS = 8,
    parameter int         DEPTH      = 2,
    parameter logic [3:0] AXI_ID     = 4'd1
) (
    input logic           clk,
    input logic           reset,
    dcache_wbuf_if.master bus
);
    localparam int OFF    = $clog2(LINE_WORDS) + 2;
    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
    localparam logic [31:0]       LINE_MASK = ~((32'd1 << OFF) - 32'd1);

    typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;

    logic [DEPTH-1:0][31:0]                 addr_q, addr_d;
    logic [DEPTH-1:0][LINE_WORDS-1:0][31:0] data_q, data_d;

    logic push, pop;
    logic awvalid, wvalid, bready;
    logic q_hit;
    logic [31:0] q_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // k-th oldest resident slot, k = 0 is the head
    function automatic logic [PTR_W-1:0] age_idx(input logic [PTR_W-1:0] h, input int k);
        return PTR_W'((int'(h) + k) % DEPTH);
    endfunction

    assign push = bus.wb_valid & bus.wb_ready;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        pop     = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        case (state_q)
            S_IDLE: if (count_q != '0) state_d = S_AW;
            S_AW: begin
                awvalid = 1'b1;
                if (bus.awready) begin
                    state_d = S_W;
                    beat_d  = '0;
                end
            end
            S_W: begin
                wvalid = 1'b1;
                if (bus.wready) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) state_d = S_B;
                end
            end
            S_B: begin
                bready = 1'b1;
                // Response code is ignored: the line leaves the buffer on any B.
                if (bus.bvalid) begin
                    pop     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        head_d  = pop  ? ptr_inc(head_q) : head_q;
        tail_d  = push ? ptr_inc(tail_q) : tail_q;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        addr_d  = addr_q;
        data_d  = data_q;
        if (push) begin
            addr_d[tail_q] = bus.wb_addr & LINE_MASK;
            data_d[tail_q] = bus.wb_data;
        end
    end

    // Oldest-to-youngest scan so the youngest match overrides the forwarded word.
    always_comb begin
        q_hit  = 1'b0;
        q_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (k < int'(count_q) &&
                addr_q[age_idx(head_q, k)] == (bus.q_addr & LINE_MASK)) begin
                q_hit = 1'b1;
`ifdef DCACHE_WBUF_FWD_EN
                q_data = data_q[age_idx(head_q, k)][bus.q_addr[OFF-1:2]];
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            beat_q  <= beat_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    assign bus.wb_ready = (count_q != FULL_CNT);
    assign bus.empty    = (count_q == '0) && (state_q == S_IDLE);
    assign bus.q_hit    = q_hit;
    assign bus.q_data   = q_data;

    assign bus.awid    = AXI_ID;
    assign bus.awaddr  = addr_q[head_q];
    assign bus.awlen   = 4'(LINE_WORDS - 1);
    assign bus.awsize  = 3'b010;
    assign bus.awburst = 2'b01;
    assign bus.awlock  = 2'b00;
    assign bus.awcache = 4'b0000;
    assign bus.awprot  = 3'b000;
    assign bus.awvalid = awvalid;

    assign bus.wid    = AXI_ID;
    assign bus.wdata  = data_q[head_q][beat_q];
    assign bus.wstrb  = 4'hF;
    assign bus.wlast  = (state_q == S_W) && (beat_q == LAST_BEAT);
    assign bus.wvalid = wvalid;
    assign bus.bready = bready;

    logic unused_ok;
    assign unused_ok = ^{bus.bid, bus.bresp, bus.wb_addr[OFF-1:0], bus.q_addr[OFF-1:0]};
endmodule

// File: tb/tb_dcache_wbuf.sv
// Scoreboard bench for dcache_wbuf: expected AW addresses and W beats are queued at enqueue time
// and retired as the AXI handshakes appear.
module tb_dcache_wbuf;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;

    dcache_wbuf_if #(.LINE_WORDS(LW)) bus();

    dcache_wbuf #(.LINE_WORDS(LW), .DEPTH(2), .AXI_ID(4'd1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int aw_cnt = 0;
    int w_beats = 0;
    logic [31:0] exp_aw[$];
    logic [32:0] exp_w[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic enq(input logic [31:0] a, input logic [31:0] base);
        logic [31:0] w;
        bus.wb_valid = 1'b1;
        bus.wb_addr  = a;
        for (int i = 0; i < LW; i++) begin
            w = base + 32'(i);
            bus.wb_data[i*32 +: 32] = w;
            exp_w.push_back({1'(i == LW - 1), w});
        end
        exp_aw.push_back(a & ~32'h1F);
        @(posedge clk);
        #1 bus.wb_valid = 1'b0;
    endtask

    task automatic wait_empty(input string tag);
        int c = 0;
        while (!bus.empty && c < 300) begin
            @(posedge clk);
            #1 c++;
        end
        chk(tag, 64'(bus.empty), 1);
    endtask

    task automatic wait_bready(input string tag);
        int c = 0;
        while (!bus.bready && c < 300) begin
            @(posedge clk);
            #1 c++;
        end
        chk(tag, 64'(bus.bready), 1);
    endtask

    // AXI monitor: outputs sampled on the falling edge, handshakes complete on the next rising edge
    always @(negedge clk) begin
        if (!reset) begin
            chk("aw_w_exclusive", 64'(bus.awvalid & bus.wvalid), 0);
            if (bus.awvalid) begin
                chk("aw_pending", 64'(exp_aw.size() != 0), 1);
                if (exp_aw.size() != 0) begin
                    chk("awaddr", bus.awaddr, exp_aw[0]);
                    if (bus.awready) begin
                        chk("aw_fields", {bus.awid, bus.awlen, bus.awsize, bus.awburst,
                                          bus.awlock, bus.awcache, bus.awprot},
                            {4'd1, 4'd7, 3'b010, 2'b01, 2'b00, 4'd0, 3'd0});
                        void'(exp_aw.pop_front());
                        aw_cnt++;
                    end
                end
            end
            if (bus.wvalid) begin
                chk("w_pending", 64'(exp_w.size() != 0), 1);
                if (exp_w.size() != 0) begin
                    // compared every valid cycle, so a stalled beat must hold its word
                    chk("wbeat", {bus.wlast, bus.wdata}, exp_w[0]);
                    if (bus.wready) begin
                        chk("w_fields", {bus.wid, bus.wstrb}, {4'd1, 4'hF});
                        void'(exp_w.pop_front());
                        w_beats++;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int aw0, w0, c;
        logic [3:0] pat;

        bus.wb_valid = 1'b0;
        bus.wb_addr  = '0;
        bus.wb_data  = '0;
        bus.q_addr   = '0;
        bus.awready  = 1'b0;
        bus.wready   = 1'b0;
        bus.bvalid   = 1'b0;
        bus.bid      = '0;
        bus.bresp    = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst_wb_ready", 64'(bus.wb_ready), 1);
        chk("rst_empty",    64'(bus.empty),    1);
        chk("rst_awvalid",  64'(bus.awvalid),  0);
        chk("rst_wvalid",   64'(bus.wvalid),   0);
        chk("rst_bready",   64'(bus.bready),   0);
        chk("rst_q_hit",    64'(bus.q_hit),    0);

        // single line, no backpressure
        bus.awready = 1'b1; bus.wready = 1'b1; bus.bvalid = 1'b1;
        aw0 = aw_cnt; w0 = w_beats;
        enq(32'h1000_0024, 32'hA0);
        chk("t1_not_empty", 64'(bus.empty), 0);
        wait_empty("t1_empty");
        chk("t1_aw_count", 64'(aw_cnt - aw0), 1);
        chk("t1_beats", 64'(w_beats - w0), 8);

        // fill both entries while AW is stalled
        bus.awready = 1'b0;
        enq(32'h1000_0000, 32'hB0);
        chk("t2_ready_one", 64'(bus.wb_ready), 1);
        enq(32'h1000_1000, 32'hC0);
        chk("t2_full", 64'(bus.wb_ready), 0);
        bus.q_addr = 32'h1000_1008;
        #1 chk("t2_probe_tail_hit", 64'(bus.q_hit), 1);
`ifdef DCACHE_WBUF_FWD_EN
        chk("t2_probe_tail_data", bus.q_data, 32'hC2);
`else
        chk("t2_probe_tail_data", bus.q_data, 32'h0);
`endif
        bus.q_addr = 32'h1000_0010;
        #1 chk("t2_probe_head_aw", 64'(bus.q_hit), 1);
        bus.q_addr = 32'h0;
        bus.awready = 1'b1;
        c = 0;
        while (c < 300) begin
            @(negedge clk);
            if (bus.bready && bus.bvalid) break;
            chk("t2_hold_full", 64'(bus.wb_ready), 0);
            c++;
        end
        chk("t2_first_b", 64'(c < 300), 1);
        @(posedge clk);
        #1 chk("t2_ready_after_b", 64'(bus.wb_ready), 1);
        wait_empty("t2_empty");

        // W backpressure pattern 1,0,0,1
        bus.wready = 1'b0;
        aw0 = aw_cnt; w0 = w_beats;
        enq(32'h1000_2040, 32'hD0);
        pat = 4'b1001;
        for (int i = 0; i < 300; i++) begin
            bus.wready = pat[i % 4];
            @(posedge clk);
            #1;
            if (bus.empty) break;
        end
        bus.wready = 1'b1;
        chk("t3_empty", 64'(bus.empty), 1);
        chk("t3_beats", 64'(w_beats - w0), 8);

        // probe while the head waits in B
        bus.bvalid = 1'b0;
        enq(32'h1000_0024, 32'hA0);
        wait_bready("t4_reach_b");
        bus.q_addr = 32'h1000_003C;
        #1 chk("t4_hit_in_b", 64'(bus.q_hit), 1);
`ifdef DCACHE_WBUF_FWD_EN
        chk("t4_fwd_data", bus.q_data, 32'hA7);
`else
        chk("t4_fwd_data", bus.q_data, 32'h0);
`endif
        bus.q_addr = 32'h1000_0040;
        #1 chk("t4_miss_next_line", 64'(bus.q_hit), 0);
        bus.q_addr = 32'h1000_003C;
        @(posedge clk);
        #1 chk("t4_hit_still_b", 64'(bus.q_hit), 1);
        bus.bvalid = 1'b1;
        @(posedge clk);
        #1 bus.bvalid = 1'b0;
        chk("t4_hit_after_b", 64'(bus.q_hit), 0);
        chk("t4_empty", 64'(bus.empty), 1);

        // pop and push in the same cycle
        aw0 = aw_cnt;
        enq(32'h3000_0000, 32'hE0);
        wait_bready("t5_reach_b");
        bus.bvalid = 1'b1;
        enq(32'h2000_0080, 32'hF0);
        bus.bvalid = 1'b0;
        chk("t5_count_one", 64'(bus.wb_ready), 1);
        chk("t5_not_empty", 64'(bus.empty), 0);
        bus.q_addr = 32'h2000_0084;
        #1 chk("t5_new_resident", 64'(bus.q_hit), 1);
        bus.bvalid = 1'b1;
        wait_empty("t5_empty");
        chk("t5_aw_count", 64'(aw_cnt - aw0), 2);

        // asynchronous reset in the middle of the W burst
        w0 = w_beats;
        enq(32'h4000_0100, 32'h50);
        bus.q_addr = 32'h4000_0100;
        c = 0;
        while (c < 300) begin
            @(posedge clk);
            #2;
            if (w_beats - w0 >= 3) break;
            c++;
        end
        #1 chk("t6_mid_w", 64'(bus.wvalid), 1);
        chk("t6_pre_hit", 64'(bus.q_hit), 1);
        reset = 1'b1;
        exp_aw.delete();
        exp_w.delete();
        #1;
        chk("t6_awvalid", 64'(bus.awvalid), 0);
        chk("t6_wvalid",  64'(bus.wvalid),  0);
        chk("t6_wlast",   64'(bus.wlast),   0);
        chk("t6_bready",  64'(bus.bready),  0);
        chk("t6_q_hit",   64'(bus.q_hit),   0);
        chk("t6_empty",   64'(bus.empty),   1);
        chk("t6_wb_ready", 64'(bus.wb_ready), 1);
        @(posedge clk);
        #1 reset = 1'b0;
        aw0 = aw_cnt; w0 = w_beats;
        enq(32'h4000_0200, 32'h60);
        wait_empty("t6_restart_empty");
        chk("t6_restart_aw", 64'(aw_cnt - aw0), 1);
        chk("t6_restart_beats", 64'(w_beats - w0), 8);

        chk("sb_aw_drained", 64'(exp_aw.size()), 0);
        chk("sb_w_drained",  64'(exp_w.size()),  0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
